// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the buffered UART transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - host write port and FIFO status of the transmitter
interface uart_tx_buffered_if #(
   parameter int FIFO_DEPTH = 8
) ();

   logic                          wr_en;
   logic [7:0]                    data_in;
   logic                          full;
   logic                          empty;
   logic [$clog2(FIFO_DEPTH):0]   count;
   logic                          overflow;

   modport master (
      output wr_en,
      output data_in,
      input  full,
      input  empty,
      input  count,
      input  overflow
   );

   modport slave (
      input  wr_en,
      input  data_in,
      output full,
      output empty,
      output count,
      output overflow
   );

endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with registered full/empty/count/overflow
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = DATA_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty differ when the indices match
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_acc;
   logic             rd_acc;

   // A write is judged against the registered full flag, before any same-cycle pop
   assign wr_acc = wr_en & ~full_q;
   assign rd_acc = rd_en & ~empty_q;

   // Next pointer, occupancy and flag values
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d    = wr_ptr_d - rd_ptr_d;
      empty_d    = (wr_ptr_d == rd_ptr_d);
      full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      overflow_d = wr_en & full_q;
   end

   // Pointer and status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage array; contents become stale on reset because the pointers are cleared
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter with optional even parity
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 8,
   parameter int PARITY_EN    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_en,
   uart_tx_buffered_if.slave     host,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t      state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           par_q, par_d;
   logic           tx_q, tx_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           bit_end;
   logic           pop;
   logic [7:0]     fifo_data;

   assign bit_end = (baud_q == BAUD_LAST);
   // A new frame may start from IDLE or straight out of the final stop-bit cycle
   assign pop = ((state_q == IDLE) || ((state_q == STOP) && bit_end)) &&
                tx_en && !host.empty;

   uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (host.wr_en),
      .wr_data  (host.data_in),
      .rd_en    (pop),
      .rd_data  (fifo_data),
      .full     (host.full),
      .empty    (host.empty),
      .count    (host.count),
      .overflow (host.overflow)
   );

   // Next state plus outputs derived from the next state, so registered outputs line up with state_q
   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (pop) begin
               state_d = START;
               shift_d = fifo_data;
               par_d   = ^fifo_data;
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (pop) begin
                  state_d = START;
                  shift_d = fifo_data;
                  par_d   = ^fifo_data;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = START_BIT;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = STOP_BIT;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
   end

   // Frame state and registered line outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

   logic clk;
   logic rst_n;
   logic tx_en_a, tx_en_b;
   logic tx_a, busy_a, done_a;
   logic tx_b, busy_b, done_b;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   idle_bad;

   uart_tx_buffered_if #(.FIFO_DEPTH(8)) bus_a ();
   uart_tx_buffered_if #(.FIFO_DEPTH(8)) bus_b ();

   uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .PARITY_EN(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .tx_en (tx_en_a),
      .host  (bus_a),
      .tx    (tx_a),
      .busy  (busy_a),
      .done  (done_a)
   );

   uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .PARITY_EN(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .tx_en (tx_en_b),
      .host  (bus_b),
      .tx    (tx_b),
      .busy  (busy_b),
      .done  (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par);
      logic [10:0] r;
      r      = '1;
      r[0]   = 1'b0;
      r[8:1] = b;
      if (par) r[9] = ^b;
      return r;
   endfunction

   // Starts at the negedge before frame cycle 1 and ends on the final stop-bit cycle
   task automatic check_frame(input bit which, input logic [7:0] b, input string tag);
      int          nb;
      logic [10:0] bits;
      nb   = which ? 10 : 11;
      bits = frame_bits(b, !which);
      for (int k = 0; k < nb * 4; k++) begin
         @(negedge clk);
         chk({tag, " tx"},   32'(which ? tx_b : tx_a),     32'(bits[k / 4]));
         chk({tag, " busy"}, 32'(which ? busy_b : busy_a), 1);
         chk({tag, " done"}, 32'(which ? done_b : done_a), (k == nb * 4 - 1) ? 1 : 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      tx_en_a = 1'b0;
      tx_en_b = 1'b0;
      bus_a.wr_en = 1'b0;
      bus_a.data_in = 8'h00;
      bus_b.wr_en = 1'b0;
      bus_b.data_in = 8'h00;
      repeat (3) @(negedge clk);

      chk("rst tx_a", 32'(tx_a), 1);
      chk("rst busy_a", 32'(busy_a), 0);
      chk("rst done_a", 32'(done_a), 0);
      chk("rst full_a", 32'(bus_a.full), 0);
      chk("rst empty_a", 32'(bus_a.empty), 1);
      chk("rst count_a", 32'(bus_a.count), 0);
      chk("rst ovf_a", 32'(bus_a.overflow), 0);
      chk("rst tx_b", 32'(tx_b), 1);
      chk("rst busy_b", 32'(busy_b), 0);
      chk("rst empty_b", 32'(bus_b.empty), 1);

      rst_n = 1'b1;
      tx_en_a = 1'b1;
      tx_en_b = 1'b1;

      // Single parity frame of 0xA5
      @(negedge clk);
      bus_a.wr_en = 1'b1;
      bus_a.data_in = 8'hA5;
      @(negedge clk);
      bus_a.wr_en = 1'b0;
      chk("t1 count", 32'(bus_a.count), 1);
      chk("t1 empty", 32'(bus_a.empty), 0);
      chk("t1 busy pre", 32'(busy_a), 0);
      check_frame(1'b0, 8'hA5, "t1");
      @(negedge clk);
      chk("t1 busy post", 32'(busy_a), 0);
      chk("t1 tx post", 32'(tx_a), 1);
      chk("t1 done post", 32'(done_a), 0);
      chk("t1 empty post", 32'(bus_a.empty), 1);

      // No-parity frame of 0x3C
      @(negedge clk);
      bus_b.wr_en = 1'b1;
      bus_b.data_in = 8'h3C;
      @(negedge clk);
      bus_b.wr_en = 1'b0;
      check_frame(1'b1, 8'h3C, "t2");
      @(negedge clk);
      chk("t2 busy post", 32'(busy_b), 0);
      chk("t2 tx post", 32'(tx_b), 1);

      // Fill to full with transmission held, overflow on the ninth write, then drain
      tx_en_a = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 8) begin
            chk("t3 count7", 32'(bus_a.count), 7);
            chk("t3 full7", 32'(bus_a.full), 0);
         end
         if (i == 9) begin
            chk("t3 count8", 32'(bus_a.count), 8);
            chk("t3 full8", 32'(bus_a.full), 1);
            chk("t3 ovf pre", 32'(bus_a.overflow), 0);
         end
         bus_a.wr_en = 1'b1;
         bus_a.data_in = 8'(i);
      end
      @(negedge clk);
      bus_a.wr_en = 1'b0;
      chk("t3 ovf", 32'(bus_a.overflow), 1);
      chk("t3 count hold", 32'(bus_a.count), 8);
      @(negedge clk);
      chk("t3 ovf clear", 32'(bus_a.overflow), 0);
      chk("t3 idle held", 32'(busy_a), 0);
      tx_en_a = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check_frame(1'b0, 8'(i), "t3 frame");
      end
      chk("t3 empty", 32'(bus_a.empty), 1);
      chk("t3 count0", 32'(bus_a.count), 0);
      @(negedge clk);
      chk("t3 busy end", 32'(busy_a), 0);

      // Back-to-back 0x00 and 0xFF with no idle gap
      tx_en_a = 1'b0;
      @(negedge clk);
      bus_a.wr_en = 1'b1;
      bus_a.data_in = 8'h00;
      @(negedge clk);
      bus_a.data_in = 8'hFF;
      @(negedge clk);
      bus_a.wr_en = 1'b0;
      chk("t4 count", 32'(bus_a.count), 2);
      tx_en_a = 1'b1;
      check_frame(1'b0, 8'h00, "t4 first");
      check_frame(1'b0, 8'hFF, "t4 second");
      @(negedge clk);
      chk("t4 busy end", 32'(busy_a), 0);

      // Reset during data bit 3 of 0x55 with a second byte queued
      @(negedge clk);
      bus_a.wr_en = 1'b1;
      bus_a.data_in = 8'h55;
      @(negedge clk);
      bus_a.data_in = 8'h11;
      @(negedge clk);
      bus_a.wr_en = 1'b0;
      chk("t5 start tx", 32'(tx_a), 0);
      chk("t5 count", 32'(bus_a.count), 1);
      repeat (17) @(negedge clk);
      chk("t5 bit3 tx", 32'(tx_a), 0);
      chk("t5 bit3 busy", 32'(busy_a), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5 rst tx", 32'(tx_a), 1);
      chk("t5 rst busy", 32'(busy_a), 0);
      chk("t5 rst count", 32'(bus_a.count), 0);
      chk("t5 rst empty", 32'(bus_a.empty), 1);
      chk("t5 rst done", 32'(done_a), 0);
      rst_n = 1'b1;
      idle_bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) idle_bad++;
      end
      chk("t5 idle after reset", 32'(idle_bad), 0);

      // Write to a full FIFO on the same cycle it pops
      tx_en_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus_a.wr_en = 1'b1;
         bus_a.data_in = 8'(8'h80 + i);
      end
      @(negedge clk);
      chk("t6 full", 32'(bus_a.full), 1);
      chk("t6 count8", 32'(bus_a.count), 8);
      bus_a.data_in = 8'h77;
      tx_en_a = 1'b1;
      @(negedge clk);
      bus_a.wr_en = 1'b0;
      tx_en_a = 1'b0;
      chk("t6 ovf", 32'(bus_a.overflow), 1);
      chk("t6 count7", 32'(bus_a.count), 7);
      chk("t6 full clear", 32'(bus_a.full), 0);
      chk("t6 start tx", 32'(tx_a), 0);
      repeat (43) @(negedge clk);
      chk("t6 done", 32'(done_a), 1);
      @(negedge clk);
      chk("t6 no relaunch", 32'(busy_a), 0);
      chk("t6 count kept", 32'(bus_a.count), 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter. It is the transmit-side peer of the existing UART receiver, which checks parity on `err`.
- Accepts bytes from a host write port into an internal FIFO and serialises them on `tx`.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional even-parity bit, 1 stop bit (1).
- Sits beside the receiver in the UART subsystem. It replaces the single-byte transmit path when the host needs to queue bursts.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per serial bit; legal range 2 or more.
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- tx_en  input  1  enables launching new frames; a frame in flight always completes.
- wr_en  input  1  write strobe for data_in.
- data_in  input  8  byte to enqueue.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line (states other than IDLE).
- done  output  1  one-cycle pulse on the last cycle of each stop bit.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset: when rst_n is sampled low, the next edge sets tx=1, busy=0, done=0, overflow=0, full=0, empty=1, count=0, state=IDLE, bit counter=0, baud counter=0. FIFO contents are discarded.
- A reset asserted mid-frame aborts the frame: tx returns high on the next edge and no done pulse is produced.
- Outputs tx, busy, done, full, empty, count and overflow are all registered.
- FIFO write:
  - On wr_en=1 with full=0, data_in is stored and count increments the next cycle.
  - On wr_en=1 with full=1, the write is dropped, overflow pulses high for 1 cycle, and contents and count are unchanged.
  - `full` is evaluated before any pop in the same cycle, so a write to a full FIFO is rejected even if a pop occurs that cycle.
  - A simultaneous accepted write and pop leaves count unchanged.
- Pop condition: (state==IDLE, or last cycle of STOP) and tx_en=1 and empty=0. The popped byte loads the shift register and the parity register (XOR of the byte), and the state moves to START on the next edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. Go to START on the pop condition.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7 (a 3-bit counter that wraps to 0), go to PARITY if PARITY_EN=1, otherwise STOP.
  - PARITY: tx=parity for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. done pulses on the final cycle. Next state is START if the pop condition holds that cycle (back-to-back frames, no idle gap), otherwise IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - A bit boundary is the cycle where the counter equals CLKS_PER_BIT-1.
- Latency: the first tx low edge is 1 cycle after the pop cycle. The earliest pop is 1 cycle after the accepted write, once empty=0 is registered.
- Frame length: (11 if PARITY_EN else 10) × CLKS_PER_BIT cycles.
- tx_en deasserted mid-frame: the current frame completes and no further pops occur.
- tx_en asserted with an empty FIFO: the block stays in IDLE.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8.
- Sub-module uart_fifo: synchronous FIFO with DEPTH and WIDTH parameters.
  - Write/read strobes, full, empty, count.
  - Pointers one bit wider than the address, so full and empty can be distinguished on wrap-around.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Write 0xA5 with tx_en=1, PARITY_EN=1 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles; done pulses at frame cycle 44; busy high for 44 cycles.
- PARITY_EN=0, write 0x3C -> 10 bits 0,0,0,1,1,1,1,0,0,1; frame length 40 cycles.
- With tx_en=0, write 9 bytes 0x01..0x09 -> full=1 and count=8 after the 8th write; overflow pulses once on the 9th write. Then set tx_en=1 -> bytes 0x01..0x08 are sent in order and empty=1 after the 8th pop.
- Queue 0x00 then 0xFF, then set tx_en=1 -> the second start bit begins on the cycle right after the first stop bit's last cycle (no idle gap); two done pulses 44 cycles apart.
- Assert rst_n=0 during DATA bit 3 of 0x55 -> on the next edge tx=1, busy=0, count=0, empty=1; no done pulse; tx stays idle after release.
- Write on the same cycle the FIFO pops while count=8 -> write rejected, overflow pulses, count=7 the next cycle.
